// File: rtl/decode_queue.sv
// decode_queue: fetch-to-ID instruction buffer with pre-decode, load-use bubble and flush.
// Optional: define DELAY_SLOT_KEEP_EN to let flush_keep_slot retain the output slot on flush.
module decode_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        flush_keep_slot,
    input  logic        in_valid,
    input  logic        in_two,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic        out_uses_rs,
    output logic        out_uses_rt,
    output logic        out_rf_we,
    output logic [4:0]  out_rf_waddr,
    output logic        out_is_load,
    output logic        out_is_store,
    output logic        out_is_br,
    output logic        out_ri,
    output logic        stallreq
);
    localparam int AW = CNT_W - 1;

    typedef struct packed {
        logic       uses_rs;
        logic       uses_rt;
        logic       rf_we;
        logic [4:0] rf_waddr;
        logic       is_load;
        logic       is_store;
        logic       is_br;
        logic       ri;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t d;
        // NOTE: default every field first so each path through the cases is fully assigned.
        d = '0;
        case (inst[31:26])
            6'h00: case (inst[5:0])
                6'h00, 6'h02, 6'h03: begin
                    d.uses_rt = 1'b1; d.rf_we = 1'b1; d.rf_waddr = inst[15:11];
                end
                6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                    d.uses_rs = 1'b1; d.uses_rt = 1'b1;
                    d.rf_we = 1'b1; d.rf_waddr = inst[15:11];
                end
                6'h08: begin d.uses_rs = 1'b1; d.is_br = 1'b1; end
                6'h09: begin
                    d.uses_rs = 1'b1; d.is_br = 1'b1;
                    d.rf_we = 1'b1; d.rf_waddr = inst[15:11];
                end
                6'h0C, 6'h0D: begin end
                6'h10, 6'h12: begin d.rf_we = 1'b1; d.rf_waddr = inst[15:11]; end
                6'h11, 6'h13: d.uses_rs = 1'b1;
                6'h18, 6'h19, 6'h1A, 6'h1B: begin d.uses_rs = 1'b1; d.uses_rt = 1'b1; end
                default: d.ri = 1'b1;
            endcase
            6'h01: case (inst[20:16])
                5'h00, 5'h01: begin d.uses_rs = 1'b1; d.is_br = 1'b1; end
                5'h10, 5'h11: begin
                    d.uses_rs = 1'b1; d.is_br = 1'b1;
                    d.rf_we = 1'b1; d.rf_waddr = 5'd31;
                end
                default: d.ri = 1'b1;
            endcase
            6'h02: d.is_br = 1'b1;
            6'h03: begin d.is_br = 1'b1; d.rf_we = 1'b1; d.rf_waddr = 5'd31; end
            6'h04, 6'h05: begin d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.is_br = 1'b1; end
            6'h06, 6'h07: begin d.uses_rs = 1'b1; d.is_br = 1'b1; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                d.uses_rs = 1'b1; d.rf_we = 1'b1; d.rf_waddr = inst[20:16];
            end
            6'h0F: begin d.rf_we = 1'b1; d.rf_waddr = inst[20:16]; end
            6'h10: begin
                if (inst[25:21] == 5'h00) begin
                    d.rf_we = 1'b1; d.rf_waddr = inst[20:16];
                end else if (inst[25:21] == 5'h04) begin
                    d.uses_rt = 1'b1;
                end else if (!(inst[25:21] == 5'h10 && inst[5:0] == 6'h18)) begin
                    d.ri = 1'b1;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                d.uses_rs = 1'b1; d.is_load = 1'b1;
                d.rf_we = 1'b1; d.rf_waddr = inst[20:16];
            end
            6'h28, 6'h29, 6'h2B: begin d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.is_store = 1'b1; end
            default: d.ri = 1'b1;
        endcase
        if (d.ri || d.rf_waddr == 5'd0) d.rf_we = 1'b0;
        return d;
    endfunction

    logic [31:0]    pc_q   [DEPTH];
    logic [31:0]    inst_q [DEPTH];
    logic [AW-1:0]  head, tail, tail_p1;
    logic [CNT_W-1:0] count, enq_n, deq_n;
    dec_t           head_dec, out_dec;
    logic           enq, consume, hazard, load;

    assign in_ready = (count <= CNT_W'(DEPTH - 2));
    assign enq      = in_valid && in_ready && !flush;
    assign tail_p1  = tail + AW'(1);
    assign consume  = out_valid && out_ready;
    assign head_dec = decode(inst_q[head]);

    // A load in the slot leaving this cycle feeds a head that reads its result: hold the head.
    assign hazard = consume && (count != '0) && out_dec.is_load && out_dec.rf_we &&
                    (out_dec.rf_waddr != 5'd0) &&
                    ((head_dec.uses_rs && inst_q[head][25:21] == out_dec.rf_waddr) ||
                     (head_dec.uses_rt && inst_q[head][20:16] == out_dec.rf_waddr));
    assign load   = (!out_valid || out_ready) && (count != '0) && !hazard;
    assign enq_n  = enq ? (in_two ? CNT_W'(2) : CNT_W'(1)) : '0;
    assign deq_n  = CNT_W'(load);

    // NOTE: storage carries no reset; head/tail/count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            pc_q[tail]   <= in_pc;
            inst_q[tail] <= in_inst0;
            if (in_two) begin
                pc_q[tail_p1]   <= in_pc + 32'd4;
                inst_q[tail_p1] <= in_inst1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
            out_dec   <= '0;
            stallreq  <= 1'b0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            stallreq <= 1'b0;
`ifdef DELAY_SLOT_KEEP_EN
            if (!flush_keep_slot || out_ready) out_valid <= 1'b0;
`else
            out_valid <= 1'b0;
`endif
        end else begin
            if (enq) tail <= in_two ? tail + AW'(2) : tail_p1;
            count    <= count + enq_n - deq_n;
            stallreq <= hazard;
            if (load) begin
                out_valid <= 1'b1;
                out_pc    <= pc_q[head];
                out_inst  <= inst_q[head];
                out_dec   <= head_dec;
                head      <= head + AW'(1);
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifndef DELAY_SLOT_KEEP_EN
    logic unused_keep;
    assign unused_keep = flush_keep_slot;
`endif

    assign out_rs       = out_inst[25:21];
    assign out_rt       = out_inst[20:16];
    assign out_uses_rs  = out_dec.uses_rs;
    assign out_uses_rt  = out_dec.uses_rt;
    assign out_rf_we    = out_dec.rf_we;
    assign out_rf_waddr = out_dec.rf_waddr;
    assign out_is_load  = out_dec.is_load;
    assign out_is_store = out_dec.is_store;
    assign out_is_br    = out_dec.is_br;
    assign out_ri       = out_dec.ri;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed self-checking bench for decode_queue (DEPTH=8).
module tb_decode_queue;
    logic        clk = 1'b0;
    logic        rst, flush, flush_keep_slot, in_valid, in_two, out_ready;
    logic [31:0] in_pc, in_inst0, in_inst1;
    logic        in_ready, out_valid, out_uses_rs, out_uses_rt, out_rf_we;
    logic        out_is_load, out_is_store, out_is_br, out_ri, stallreq;
    logic [31:0] out_pc, out_inst;
    logic [4:0]  out_rs, out_rt, out_rf_waddr;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    decode_queue #(.DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_keep_slot(flush_keep_slot),
        .in_valid(in_valid), .in_two(in_two), .in_pc(in_pc),
        .in_inst0(in_inst0), .in_inst1(in_inst1), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rs(out_rs), .out_rt(out_rt), .out_uses_rs(out_uses_rs), .out_uses_rt(out_uses_rt),
        .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr), .out_is_load(out_is_load),
        .out_is_store(out_is_store), .out_is_br(out_is_br), .out_ri(out_ri), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic two, input logic [31:0] pc, input logic [31:0] i0,
                         input logic [31:0] i1);
        in_valid = 1'b1;
        in_two   = two;
        in_pc    = pc;
        in_inst0 = i0;
        in_inst1 = i1;
    endtask

    localparam logic [31:0] ADDIU_2_0_5 = 32'h24020005;
    localparam logic [31:0] ADDU_3_2_2  = 32'h00421821;
    localparam logic [31:0] LW_4_0_1    = 32'h8C240000;
    localparam logic [31:0] ADDU_5_4_0  = 32'h00802821;
    localparam logic [31:0] ADDU_5_6_0  = 32'h00C02821;
    localparam logic [31:0] JAL_100     = 32'h0C000040;
    localparam logic [31:0] SLL_NOP     = 32'h00000000;
    localparam logic [31:0] OP_3F       = 32'hFC000000;

    initial begin
        int pairs;
        logic [31:0] pc_next;

        rst = 1'b1; flush = 1'b0; flush_keep_slot = 1'b0; in_valid = 1'b0; in_two = 1'b0;
        out_ready = 1'b0; in_pc = '0; in_inst0 = '0; in_inst1 = '0;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stallreq", stallreq, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_rf_we", out_rf_we, 0);
        rst = 1'b0;

        // Two-wide fetch into an empty queue, consumer always ready.
        out_ready = 1'b1;
        drive(1'b1, 32'hBFC00000, ADDIU_2_0_5, ADDU_3_2_2);
        tick();
        in_valid = 1'b0;
        check("lat_not_yet", out_valid, 0);
        tick();
        check("first_valid", out_valid, 1);
        check("first_pc", out_pc, 32'hBFC00000);
        check("first_waddr", out_rf_waddr, 2);
        check("first_we", out_rf_we, 1);
        check("first_uses_rs", out_uses_rs, 1);
        tick();
        check("second_valid", out_valid, 1);
        check("second_pc", out_pc, 32'hBFC00004);
        check("second_waddr", out_rf_waddr, 3);
        check("second_uses_rt", out_uses_rt, 1);
        tick();
        check("drained_valid", out_valid, 0);

        // Fill with the consumer stalled; storage wraps because head/tail start at 2.
        out_ready = 1'b0;
        pairs = 0;
        pc_next = 32'h00001000;
        for (int i = 0; i < 10 && in_ready; i++) begin
            drive(1'b1, pc_next, {16'h2408, pc_next[15:0]}, {16'h2408, pc_next[15:0] + 16'd4});
            tick();
            pairs++;
            pc_next += 32'd8;
        end
        in_valid = 1'b0;
        check("fill_pairs", pairs, 4);
        check("fill_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("drain_valid", out_valid, 1);
            check("drain_pc", out_pc, 32'h00001000 + 32'(4 * j));
            tick();
        end
        check("drain_end_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);

        // Load-use: one bubble with stallreq.
        drive(1'b1, 32'h00002000, LW_4_0_1, ADDU_5_4_0);
        tick();
        in_valid = 1'b0;
        tick();
        check("lu_lw_pc", out_pc, 32'h00002000);
        check("lu_is_load", out_is_load, 1);
        check("lu_lw_waddr", out_rf_waddr, 4);
        tick();
        check("lu_bubble_valid", out_valid, 0);
        check("lu_bubble_stall", stallreq, 1);
        tick();
        check("lu_use_valid", out_valid, 1);
        check("lu_use_pc", out_pc, 32'h00002004);
        check("lu_use_stall", stallreq, 0);
        tick();
        check("lu_end_valid", out_valid, 0);

        // Independent consumer: no bubble.
        drive(1'b1, 32'h00003000, LW_4_0_1, ADDU_5_6_0);
        tick();
        in_valid = 1'b0;
        tick();
        check("nolu_lw_pc", out_pc, 32'h00003000);
        tick();
        check("nolu_valid", out_valid, 1);
        check("nolu_pc", out_pc, 32'h00003004);
        check("nolu_stall", stallreq, 0);
        tick();

        // Decode corner cases, plus a single-instruction fetch group.
        drive(1'b1, 32'h00004000, JAL_100, SLL_NOP);
        tick();
        drive(1'b0, 32'h00004008, OP_3F, 32'h0);
        tick();
        in_valid = 1'b0;
        check("jal_pc", out_pc, 32'h00004000);
        check("jal_waddr", out_rf_waddr, 31);
        check("jal_we", out_rf_we, 1);
        check("jal_uses_rs", out_uses_rs, 0);
        check("jal_uses_rt", out_uses_rt, 0);
        check("jal_is_br", out_is_br, 1);
        tick();
        check("sll_pc", out_pc, 32'h00004004);
        check("sll_we", out_rf_we, 0);
        check("sll_ri", out_ri, 0);
        tick();
        check("ri_valid", out_valid, 1);
        check("ri_pc", out_pc, 32'h00004008);
        check("ri_flag", out_ri, 1);
        check("ri_we", out_rf_we, 0);
        tick();
        check("dec_end_valid", out_valid, 0);

        // Flush with three entries queued and the slot valid; input that cycle is ignored.
        out_ready = 1'b0;
        drive(1'b1, 32'h00005000, ADDIU_2_0_5, ADDIU_2_0_5);
        tick();
        drive(1'b1, 32'h00005008, ADDIU_2_0_5, ADDIU_2_0_5);
        tick();
        in_valid = 1'b0;
        check("pre_flush_valid", out_valid, 1);
        check("pre_flush_pc", out_pc, 32'h00005000);
        flush = 1'b1;
        drive(1'b1, 32'h00006000, ADDIU_2_0_5, ADDIU_2_0_5);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_stall", stallreq, 0);
        out_ready = 1'b1;
        tick();
        check("flush_empty_1", out_valid, 0);
        tick();
        check("flush_empty_2", out_valid, 0);

        // Flush requesting delay-slot retention.
        out_ready = 1'b0;
        drive(1'b1, 32'h00007000, ADDIU_2_0_5, ADDIU_2_0_5);
        tick();
        in_valid = 1'b0;
        tick();
        check("keep_pre_valid", out_valid, 1);
        check("keep_pre_pc", out_pc, 32'h00007000);
        flush = 1'b1;
        flush_keep_slot = 1'b1;
        tick();
        flush = 1'b0;
        flush_keep_slot = 1'b0;
`ifdef DELAY_SLOT_KEEP_EN
        check("keep_valid", out_valid, 1);
        check("keep_pc", out_pc, 32'h00007000);
`else
        check("keep_ignored_valid", out_valid, 0);
`endif
        out_ready = 1'b1;
        tick();
        check("keep_after_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
